oled_spi_sink: RTL

//  Receiver/decoder for the 4-wire SSD1306-style SPI stream driven by the OLED screen driver
//  (ioSclk/ioSdin/ioCs/ioDc/ioReset). It deserialises bytes, splits command from pixel data via DC,
//  and tracks the display state registers and the GDDRAM address pointer.

---
 rtl/oled_pkg.sv | 47 ++++
 rtl/spi_byte_rx.sv | 73 +++++++
 rtl/oled_spi_sink.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: shared definitions for the SSD1306-style SPI sink.
//   - Command opcodes the decoder acts on or must count arguments for.
//   - Decoder state encoding (idle / waiting for last argument / waiting for first of two).
//   - GDDRAM addressing mode codes as carried by the 0x20 command.
//   - Helpers classifying opcodes by argument count.
package oled_pkg;

   localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
   localparam logic [7:0] OP_DISP_ON     = 8'hAF;
   localparam logic [7:0] OP_INV_OFF     = 8'hA6;
   localparam logic [7:0] OP_INV_ON      = 8'hA7;
   localparam logic [7:0] OP_CONTRAST    = 8'h81;
   localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
   localparam logic [7:0] OP_COL_ADDR    = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
   localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
   localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
   localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
   localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
   localparam logic [7:0] OP_VCOMH       = 8'hDB;
   localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;

   typedef enum logic [1:0] {
      DEC_IDLE = 2'd0,
      DEC_ARG1 = 2'd1,
      DEC_ARG2 = 2'd2
   } dec_state_t;

   typedef enum logic [1:0] {
      MODE_HORZ = 2'b00,
      MODE_VERT = 2'b01,
      MODE_PAGE = 2'b10
   } addr_mode_t;

   function automatic logic is_one_arg(input logic [7:0] op);
      case (op)
         OP_CONTRAST, OP_ADDR_MODE, OP_MUX_RATIO, OP_DISP_OFFSET,
         OP_CLK_DIV, OP_PRECHARGE, OP_VCOMH, OP_CHARGE_PUMP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_two_arg(input logic [7:0] op);
      return (op == OP_COL_ADDR) || (op == OP_PAGE_ADDR);
   endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: oversampled SPI byte receiver (mode 3 style: SCLK idle high, sample on rise).
// Ports:
//   clk, rst        system clock, synchronous active-high reset (also resets synchronisers)
//   clr             synchronous clear of the bit counter / shift register only
//   sclk,sdin,cs,dc asynchronous SPI pins (cs active low, dc sampled with bit 0)
//   byteValid       combinational 1-cycle flag in the clk where the 8th rising edge is seen
//   byteDc,byteData DC level and assembled byte (MSB first), valid with byteValid
module spi_byte_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       sclk,
   input  logic       sdin,
   input  logic       cs,
   input  logic       dc,
   output logic       byteValid,
   output logic       byteDc,
   output logic [7:0] byteData
);

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] sdin_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] dc_sync;
   logic                   sclk_prev;
   logic [2:0]             bit_cnt;
   logic [6:0]             shreg;
   logic                   sclk_s, sdin_s, cs_s, dc_s, rise;

   // Idle levels on reset so a released reset never looks like an SCLK edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '1;
         sdin_sync <= '0;
         cs_sync   <= '1;
         dc_sync   <= '0;
         sclk_prev <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
         sclk_prev <= sclk_s;
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign sdin_s = sdin_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign dc_s   = dc_sync[SYNC_STAGES-1];
   assign rise   = sclk_s & ~sclk_prev;

   // Only 7 bits are stored: the 8th bit is taken straight from the synchroniser
   // so the byte is available in the same clk as its last edge.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (cs_s) begin
         bit_cnt <= '0;
      end else if (rise) begin
         shreg   <= {shreg[5:0], sdin_s};
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   assign byteValid = rise & ~cs_s & ~clr & (bit_cnt == 3'd7);
   assign byteDc    = dc_s;
   assign byteData  = {shreg, sdin_s};

endmodule

// File: rtl/oled_spi_sink.sv
// oled_spi_sink: SSD1306-style SPI panel model / capture block.
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   ioSclk,ioSdin,ioCs,ioDc       4-wire SPI from the screen driver
//   ioReset                       panel reset, active low (synchronised)
//   fbWe,fbAddr,fbData            1-cycle framebuffer write per data byte
//   cmdStrobe,cmdByte             1-cycle pulse per command byte (opcode or argument)
//   displayOn,inverted,contrast,addrMode   decoded display registers
//   protoError                    sticky: data byte arrived while an argument was pending
module oled_spi_sink
   import oled_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COLS        = 128,
   parameter int unsigned PAGES       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ioSclk,
   input  logic       ioSdin,
   input  logic       ioCs,
   input  logic       ioDc,
   input  logic       ioReset,
   output logic       fbWe,
   output logic [9:0] fbAddr,
   output logic [7:0] fbData,
   output logic       cmdStrobe,
   output logic [7:0] cmdByte,
   output logic       displayOn,
   output logic       inverted,
   output logic [7:0] contrast,
   output logic [1:0] addrMode,
   output logic       protoError
);

   localparam logic [7:0] COL_MAX  = 8'(COLS - 1);
   localparam logic [7:0] PAGE_MAX = 8'(PAGES - 1);
   localparam logic [9:0] COLS_W   = 10'(COLS);

   logic [SYNC_STAGES-1:0] reset_sync;
   logic                   panel_rst, soft_rst;
   logic                   byte_valid, byte_dc;
   logic [7:0]             byte_data;

   dec_state_t state, state_n;
   addr_mode_t addr_mode;
   logic [7:0] op_q;
   logic [6:0] start_q;
   logic [6:0] col, col_start, col_end, col_next, col_arg;
   logic [2:0] page, page_start, page_end, page_next, page_arg;
   logic       col_wrap, page_wrap;

   always_ff @(posedge clk) begin
      if (rst) reset_sync <= '1;
      else     reset_sync <= {reset_sync[SYNC_STAGES-2:0], ioReset};
   end

   assign panel_rst = ~reset_sync[SYNC_STAGES-1];
   assign soft_rst  = rst | panel_rst;

   spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .clr      (panel_rst),
      .sclk     (ioSclk),
      .sdin     (ioSdin),
      .cs       (ioCs),
      .dc       (ioDc),
      .byteValid(byte_valid),
      .byteDc   (byte_dc),
      .byteData (byte_data)
   );

   always_ff @(posedge clk) begin
      if (soft_rst) state <= DEC_IDLE;
      else          state <= state_n;
   end

   // A data byte always abandons a pending argument sequence.
   always_comb begin
      state_n = state;
      if (byte_valid) begin
         if (byte_dc) begin
            state_n = DEC_IDLE;
         end else begin
            case (state)
               DEC_IDLE: begin
                  if (is_one_arg(byte_data))      state_n = DEC_ARG1;
                  else if (is_two_arg(byte_data)) state_n = DEC_ARG2;
               end
               DEC_ARG2: state_n = DEC_ARG1;
               default:  state_n = DEC_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      col_arg   = (byte_data > COL_MAX)  ? COL_MAX[6:0]  : byte_data[6:0];
      page_arg  = (byte_data > PAGE_MAX) ? PAGE_MAX[2:0] : byte_data[2:0];
      col_wrap  = (col == col_end);
      page_wrap = (page == page_end);
      col_next  = col_wrap  ? col_start  : col + 7'd1;
      page_next = page_wrap ? page_start : page + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (soft_rst) begin
         fbWe       <= 1'b0;
         fbAddr     <= '0;
         fbData     <= '0;
         cmdStrobe  <= 1'b0;
         cmdByte    <= '0;
         displayOn  <= 1'b0;
         inverted   <= 1'b0;
         contrast   <= 8'h7F;
         addr_mode  <= MODE_PAGE;
         col        <= '0;
         page       <= '0;
         col_start  <= '0;
         col_end    <= COL_MAX[6:0];
         page_start <= '0;
         page_end   <= PAGE_MAX[2:0];
         op_q       <= '0;
         start_q    <= '0;
      end else begin
         fbWe      <= 1'b0;
         cmdStrobe <= 1'b0;
         if (byte_valid && byte_dc) begin
            fbWe   <= 1'b1;
            fbAddr <= 10'(page) * COLS_W + 10'(col);
            fbData <= byte_data;
            case (addr_mode)
               MODE_HORZ: begin
                  col <= col_next;
                  if (col_wrap) page <= page_next;
               end
               MODE_VERT: begin
                  page <= page_next;
                  if (page_wrap) col <= col_next;
               end
               default: col <= col_next;
            endcase
         end else if (byte_valid) begin
            cmdStrobe <= 1'b1;
            cmdByte   <= byte_data;
            case (state)
               DEC_IDLE: begin
                  op_q <= byte_data;
                  case (byte_data)
                     OP_DISP_OFF: displayOn <= 1'b0;
                     OP_DISP_ON:  displayOn <= 1'b1;
                     OP_INV_OFF:  inverted  <= 1'b0;
                     OP_INV_ON:   inverted  <= 1'b1;
                     default: ;
                  endcase
               end
               DEC_ARG2: start_q <= (op_q == OP_PAGE_ADDR) ? {4'b0, page_arg} : col_arg;
               default: begin
                  case (op_q)
                     OP_CONTRAST:  contrast <= byte_data;
                     OP_ADDR_MODE: addr_mode <= (byte_data[1:0] == 2'b11) ? MODE_PAGE
                                                : addr_mode_t'(byte_data[1:0]);
                     OP_COL_ADDR: begin
                        col_start <= start_q;
                        col_end   <= col_arg;
                        col       <= start_q;
                     end
                     OP_PAGE_ADDR: begin
                        page_start <= start_q[2:0];
                        page_end   <= page_arg;
                        page       <= start_q[2:0];
                     end
                     default: ;
                  endcase
               end
            endcase
         end
      end
   end

   // Survives panel reset so a protocol fault stays visible until system reset.
   always_ff @(posedge clk) begin
      if (rst)
         protoError <= 1'b0;
      else if (!panel_rst && byte_valid && byte_dc && state != DEC_IDLE)
         protoError <= 1'b1;
   end

   assign addrMode = addr_mode;

endmodule
